// File: rtl/mult_pkg.sv
// Shared definitions for the sequential carry-save multiplier.
//   MULT_MAX_WIDTH : largest supported operand width
//   state_t / ST_* : controller state encoding
//   cnt_width()    : iteration counter width for a given operand width
package mult_pkg;

    localparam int unsigned MULT_MAX_WIDTH = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_RESOLVE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    // Counter must be able to hold WIDTH itself, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return 32'($clog2(width) + 1);
    endfunction

endpackage

// File: rtl/fa.sv
// Full adder cell.
//   a, b, cin : addends
//   s         : sum
//   cout      : carry out
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ha.sv
// Half adder cell.
//   a, b : addends
//   s    : sum
//   c    : carry out
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/seq_csa_multiplier.sv
// Iterative unsigned multiplier: one partial-product row per cycle is folded
// into a carry-save accumulator, then a single ripple pass resolves the upper
// half of the product.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b)
//   out_valid/out_ready : product handshake (p = a*b, 2*WIDTH bits)
//   busy                : high while iterating or resolving
module seq_csa_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    if (WIDTH < 2 || WIDTH > MULT_MAX_WIDTH) begin : g_bad_width
        $error("seq_csa_multiplier: WIDTH out of range");
    end

    state_t             state_r;
    state_t             state_nx;
    logic               accept;
    logic               last_iter;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // Sum is stored already shifted right by one; its LSB went to lo_r.
    logic [WIDTH-2:0]   sum_r;
    logic [WIDTH-1:0]   carry_r;
    logic [WIDTH-1:0]   lo_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [WIDTH-1:0]   row;
    logic [WIDTH-1:0]   csa_s;
    logic [WIDTH-1:0]   csa_c;

    logic [WIDTH-1:0]   res_x;
    logic [WIDTH-1:0]   rc;
    logic [WIDTH-1:0]   hi;

    // Next-state logic
    always_comb begin
        state_nx  = state_r;
        accept    = 1'b0;
        last_iter = (cnt_r == CNT_W'(WIDTH - 1));
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept   = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_iter) state_nx = ST_RESOLVE;
            end
            ST_RESOLVE: state_nx = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nx;
            in_ready  <= (state_nx == ST_IDLE);
            out_valid <= (state_nx == ST_DONE);
            busy      <= (state_nx == ST_RUN) || (state_nx == ST_RESOLVE);
        end
    end

    // Current partial-product row, selected by the multiplier LSB
    assign row = a_r & {WIDTH{b_r[0]}};

    // Carry-save row: three inputs below the top bit, two at the top bit
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_fa
        fa u_fa (
            .a   (sum_r[i]),
            .b   (carry_r[i]),
            .cin (row[i]),
            .s   (csa_s[i]),
            .cout(csa_c[i])
        );
    end

    ha u_ha (
        .a(carry_r[WIDTH-1]),
        .b(row[WIDTH-1]),
        .s(csa_s[WIDTH-1]),
        .c(csa_c[WIDTH-1])
    );

    // Ripple carry-propagate of the leftover sum and carry; cannot overflow
    assign res_x = {1'b0, sum_r};

    always_comb begin
        rc    = '0;
        for (int k = 1; k < WIDTH; k++) begin
            rc[k] = (res_x[k-1] & carry_r[k-1]) | (res_x[k-1] & rc[k-1])
                  | (carry_r[k-1] & rc[k-1]);
        end
        hi = res_x ^ carry_r ^ rc;
    end

    // Operand capture, iteration datapath and product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= '0;
            lo_r    <= '0;
            cnt_r   <= '0;
            p       <= '0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            sum_r   <= '0;
            carry_r <= '0;
            lo_r    <= '0;
            cnt_r   <= '0;
        end else if (state_r == ST_RUN) begin
            sum_r   <= csa_s[WIDTH-1:1];
            carry_r <= csa_c;
            lo_r    <= {csa_s[0], lo_r[WIDTH-1:1]};
            b_r     <= b_r >> 1;
            cnt_r   <= cnt_r + CNT_W'(1);
        end else if (state_r == ST_RESOLVE) begin
            p       <= {hi, lo_r};
        end
    end

endmodule

// File: tb/tb_seq_csa_multiplier.sv
// Self-checking bench for seq_csa_multiplier: a 16-bit instance for directed
// and random scenarios, a 4-bit instance for exhaustive operand coverage.
module tb_seq_csa_multiplier;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, busy16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;

    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_csa_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
        .p(p16), .busy(busy16)
    );

    seq_csa_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
        .p(p4), .busy(busy4)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference product for the 16-bit instance
    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y);
        return 32'(64'(x) * 64'(y));
    endfunction

    // Stimulus: one transaction on the 16-bit instance. Latency counts the
    // accept cycle as cycle 1; busy is counted once per cycle until out_valid.
    task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                         output int lat, output int bcnt, output bit ok);
        int k = 0;
        lat = 0; bcnt = 0;
        while (!ir16 && k < 200) begin
            @(negedge clk); k++;
        end
        ok = ir16;
        if (!ok) return;
        iv16 = 1'b1; a16 = av; b16 = bv;
        @(posedge clk); lat = 1;
        @(negedge clk);
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        while (!ov16 && lat < 100) begin
            if (busy16) bcnt++;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        ok = ov16;
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                        output int lat, output bit ok);
        int k = 0;
        lat = 0;
        while (!ir4 && k < 200) begin
            @(negedge clk); k++;
        end
        ok = ir4;
        if (!ok) return;
        iv4 = 1'b1; a4 = av; b4 = bv;
        @(posedge clk); lat = 1;
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        while (!ov4 && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        ok = ov4;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (ir16 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", ir16); end
        n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov16); end
        n_tests++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy16); end
        n_tests++; if (p16 !== 32'h0) begin n_fail++; $display("FAIL reset_p: got %h want 0", p16); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise16: got %b want 1", ir16); end
        n_tests++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise4: got %b want 1", ir4); end
    endtask

    task automatic test_max();
        int lat, bcnt; bit ok;
        or16 = 1'b1;
        run16(16'hFFFF, 16'hFFFF, lat, bcnt, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL max_timeout: out_valid=%b want 1", ov16); end
        n_tests++; if (p16 !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_p: got %h want fffe0001", p16); end
        n_tests++; if (lat != 18) begin n_fail++; $display("FAIL max_latency: got %0d want 18", lat); end
        n_tests++; if (bcnt != 17) begin n_fail++; $display("FAIL max_busy_cycles: got %0d want 17", bcnt); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL max_valid_clear: got %b want 0", ov16); end
        n_tests++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL max_ready_back: got %b want 1", ir16); end
    endtask

    task automatic test_zero();
        logic [15:0] za [2];
        logic [15:0] zb [2];
        int lat, bcnt; bit ok;
        za[0] = 16'h0000; zb[0] = 16'h1234;
        za[1] = 16'h00FF; zb[1] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            run16(za[i], zb[i], lat, bcnt, ok);
            n_tests++; if (!ok || p16 !== 32'h0) begin n_fail++; $display("FAIL zero_p[%0d]: got %h valid=%b want 0", i, p16, ov16); end
            n_tests++; if (lat != 18) begin n_fail++; $display("FAIL zero_latency[%0d]: got %0d want 18", i, lat); end
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat, bcnt; bit ok; int bad = 0;
        logic [31:0] exp;
        exp = ref16(16'd300, 16'd200);
        or16 = 1'b0;
        run16(16'd300, 16'd200, lat, bcnt, ok);
        n_tests++; if (!ok || p16 !== exp) begin n_fail++; $display("FAIL bp_p: got %h want %h", p16, exp); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            n_tests++;
            if (p16 !== exp || ov16 !== 1'b1 || ir16 !== 1'b0) begin
                n_fail++; bad++;
                $display("FAIL bp_hold[%0d]: p=%h valid=%b ready=%b want p=%h valid=1 ready=0", i, p16, ov16, ir16, exp);
            end
        end
        or16 = 1'b1;
        @(posedge clk); @(negedge clk);
        n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", ov16); end
        n_tests++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", ir16); end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt; bit ok; bit saw_valid = 1'b0;
        iv16 = 1'b1; a16 = 16'h00AB; b16 = 16'h00CD;
        @(posedge clk); @(negedge clk);
        iv16 = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (ir16 !== 1'b0 || ov16 !== 1'b0 || busy16 !== 1'b0 || p16 !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_async: ready=%b valid=%b busy=%b p=%h want all 0", ir16, ov16, busy16, p16);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov16) saw_valid = 1'b1;
        end
        n_tests++; if (saw_valid) begin n_fail++; $display("FAIL abort_no_valid: got out_valid=1 want never"); end
        run16(16'd3, 16'd7, lat, bcnt, ok);
        n_tests++; if (!ok || p16 !== 32'd21) begin n_fail++; $display("FAIL abort_next_p: got %h want 15", p16); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp;
        int done = 0, cyc = 0, last = -1, excl_bad = 0;
        while (!ir16 && cyc < 100) begin @(negedge clk); cyc++; end
        cyc = 0;
        or16 = 1'b1;
        iv16 = 1'b1;
        while (done < 200 && cyc < 200 * 19 + 200) begin
            if (ov16) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_spurious: got p=%h with nothing accepted", p16);
                end else begin
                    exp = q.pop_front();
                    if (p16 !== exp) begin n_fail++; $display("FAIL b2b_p[%0d]: got %h want %h", done, p16, exp); end
                end
                done++;
            end
            if (ir16 && (busy16 || ov16)) excl_bad++;
            a16 = 16'($urandom); b16 = 16'($urandom);
            if (ir16) begin
                q.push_back(ref16(a16, b16));
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last != 19) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 19", cyc - last); end
                end
                last = cyc;
            end
            @(posedge clk); @(negedge clk); cyc++;
        end
        iv16 = 1'b0;
        n_tests++; if (done != 200) begin n_fail++; $display("FAIL b2b_count: got %0d want 200", done); end
        n_tests++; if (excl_bad != 0) begin n_fail++; $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", excl_bad); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_exhaustive4();
        int lat; bit ok;
        logic [7:0] exp;
        or4 = 1'b1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                exp = 8'(ai * bi);
                run4(4'(ai), 4'(bi), lat, ok);
                n_tests++; if (!ok || p4 !== exp) begin n_fail++; $display("FAIL w4_p %0d*%0d: got %h want %h", ai, bi, p4, exp); end
                n_tests++; if (lat != 6) begin n_fail++; $display("FAIL w4_latency %0d*%0d: got %0d want 6", ai, bi, lat); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
